// File: rtl/rpa_pkg.sv
// Shared types and constants for the round_pack_arbiter slice: FSM states,
// IEEE exception flag bits and the rounding-job operand bundle.
package rpa_pkg;

    typedef enum logic [1:0] {
        RPA_IDLE,
        RPA_ISSUE,
        RPA_RESP
    } rpa_state_e;

    localparam logic [31:0] FLAG_INEXACT   = 32'd1;
    localparam logic [31:0] FLAG_UNDERFLOW = 32'd4;
    localparam logic [31:0] FLAG_OVERFLOW  = 32'd8;

    typedef struct packed {
        logic        sign;
        logic [12:0] exp;
        logic [63:0] sig;
    } rpa_operand_t;

endpackage

// File: rtl/rpa_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr_i,
// wrapping from N_REQ-1 back to 0; returns a one-hot grant and its index.
module rpa_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        any_o    = |req_i;
        // Walk offsets from farthest to nearest so the nearest hit is written last.
        for (int unsigned k = N_REQ; k > 0; k--) begin
            cand     = (32'(ptr_i) + k - 1) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                grant_o           = '0;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/round_pack_arbiter.sv
// Round-robin sequencer sharing one roundAndPackFloat64 core among N_REQ requesters.
// Define RPA_PER_REQ_FLAGS_EN for per-requester sticky flag registers and the req_flags port.
module round_pack_arbiter
    import rpa_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_sign,
    input  logic [13*N_REQ-1:0]   req_exp,
    input  logic [64*N_REQ-1:0]   req_sig,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [63:0]           resp_data,
    output logic [31:0]           flags,
    input  logic                  flags_clr,
`ifdef RPA_PER_REQ_FLAGS_EN
    output logic [32*N_REQ-1:0]   req_flags,
`endif
    output logic                  core_start,
    input  logic                  core_done,
    input  logic                  core_ready,
    output logic                  core_sign,
    output logic [12:0]           core_exp,
    output logic [63:0]           core_sig,
    output logic [31:0]           core_flag_i,
    input  logic [31:0]           core_flag_o,
    input  logic                  core_flag_vld,
    input  logic [63:0]           core_return
);

    rpa_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    rpa_operand_t      opnd_q, opnd_d;
    logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [63:0]       resp_data_q, resp_data_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic [12:0]       exp_arr [N_REQ];
    logic [63:0]       sig_arr [N_REQ];

    rpa_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            exp_arr[k] = req_exp[k*13 +: 13];
            sig_arr[k] = req_sig[k*64 +: 64];
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gidx_d       = gidx_q;
        opnd_d       = opnd_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        req_ready    = '0;
        core_start   = 1'b0;
        unique case (state_q)
            RPA_IDLE: begin
                // Accept is combinational, so hold it off while reset is asserted.
                if (pick_any && ap_rst_n) begin
                    req_ready   = pick_grant;
                    gidx_d      = pick_idx;
                    opnd_d.sign = req_sign[pick_idx];
                    opnd_d.exp  = exp_arr[pick_idx];
                    opnd_d.sig  = sig_arr[pick_idx];
                    state_d     = RPA_ISSUE;
                end
            end
            RPA_ISSUE: begin
                core_start = 1'b1;
                if (core_done && core_ready) begin
                    resp_data_d = core_return;
                    state_d     = RPA_RESP;
                end
            end
            RPA_RESP: begin
                resp_valid_d[gidx_q] = 1'b1;
                rr_ptr_d = (32'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + 1'b1;
                state_d  = RPA_IDLE;
            end
            default: state_d = RPA_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= RPA_IDLE;
            rr_ptr_q     <= '0;
            gidx_q       <= '0;
            opnd_q       <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gidx_q       <= gidx_d;
            opnd_q       <= opnd_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign core_sign  = opnd_q.sign;
    assign core_exp   = opnd_q.exp;
    assign core_sig   = opnd_q.sig;

`ifdef RPA_PER_REQ_FLAGS_EN
    logic [31:0] flags_q [N_REQ];

    // Core update is written last so it overrides a coincident clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int unsigned k = 0; k < N_REQ; k++) flags_q[k] <= '0;
        end else begin
            if (flags_clr) begin
                for (int unsigned k = 0; k < N_REQ; k++) flags_q[k] <= '0;
            end
            if (state_q == RPA_ISSUE && core_flag_vld) flags_q[gidx_q] <= core_flag_o;
        end
    end

    always_comb begin
        flags     = '0;
        req_flags = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            flags                 = flags | flags_q[k];
            req_flags[k*32 +: 32] = flags_q[k];
        end
    end

    assign core_flag_i = flags_q[gidx_q];
`else
    logic [31:0] flags_q;

    // The core ORed against the pre-clear value, so its update beats a clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            flags_q <= '0;
        end else if (state_q == RPA_ISSUE && core_flag_vld) begin
            flags_q <= core_flag_o;
        end else if (flags_clr) begin
            flags_q <= '0;
        end
    end

    assign flags       = flags_q;
    assign core_flag_i = flags_q;
`endif

endmodule

// File: tb/tb_round_pack_arbiter.sv
// Directed self-checking bench for round_pack_arbiter with a behavioural
// roundAndPackFloat64 core model (1/2/3-cycle overflow/normal/subnormal latency).
module tb_round_pack_arbiter;
    import rpa_pkg::*;

    localparam int unsigned N = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid, req_ready, req_sign, resp_valid;
    logic [13*N-1:0]   req_exp;
    logic [64*N-1:0]   req_sig;
    logic [63:0]       resp_data;
    logic [31:0]       flags;
    logic              flags_clr;
    logic              core_start, core_done, core_ready, core_sign, core_flag_vld;
    logic [12:0]       core_exp;
    logic [63:0]       core_sig, core_return;
    logic [31:0]       core_flag_i, core_flag_o;
`ifdef RPA_PER_REQ_FLAGS_EN
    logic [32*N-1:0]   req_flags;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    round_pack_arbiter #(.N_REQ(N)) dut (
        .ap_clk        (clk),
        .ap_rst_n      (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_sign      (req_sign),
        .req_exp       (req_exp),
        .req_sig       (req_sig),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .flags         (flags),
        .flags_clr     (flags_clr),
`ifdef RPA_PER_REQ_FLAGS_EN
        .req_flags     (req_flags),
`endif
        .core_start    (core_start),
        .core_done     (core_done),
        .core_ready    (core_ready),
        .core_sign     (core_sign),
        .core_exp      (core_exp),
        .core_sig      (core_sig),
        .core_flag_i   (core_flag_i),
        .core_flag_o   (core_flag_o),
        .core_flag_vld (core_flag_vld),
        .core_return   (core_return)
    );

    // Core model: cnt counts cycles since ap_start rose; done idles high.
    int unsigned cnt;
    int unsigned m_lat;
    logic [63:0] m_ret, m_z;
    logic [31:0] m_set;
    logic [9:0]  m_rb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= 0;
        else if (core_start) cnt <= cnt + 1;
        else                 cnt <= 0;
    end

    always_comb begin
        m_lat = 2;
        m_ret = '0;
        m_set = '0;
        m_z   = '0;
        m_rb  = '0;
        if ($signed(core_exp) >= $signed(13'h7FD)) begin
            m_lat = 1;
            m_ret = {core_sign, 11'h7FF, 52'd0};
            m_set = FLAG_OVERFLOW | FLAG_INEXACT;
        end else if ($signed(core_exp) <= $signed(13'h0)) begin
            m_lat = 3;
            m_ret = {core_sign, 63'd0};
            m_set = FLAG_UNDERFLOW | FLAG_INEXACT;
        end else begin
            m_rb = core_sig[9:0];
            m_z  = (core_sig + 64'h200) >> 10;
            if (m_rb == 10'h200) m_z[0] = 1'b0;
            m_ret = {core_sign, 63'd0} + ({51'd0, core_exp} << 52) + m_z;
            if (m_rb != 10'd0) m_set = FLAG_INEXACT;
        end
    end

    assign core_ready    = core_start && (cnt == m_lat);
    assign core_done     = !core_start || (cnt == m_lat);
    assign core_flag_vld = core_ready;
    assign core_flag_o   = core_flag_i | m_set;
    assign core_return   = core_ready ? m_ret : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic s, input logic [12:0] e, input logic [63:0] sg);
        req_sign[r]        = s;
        req_exp[r*13 +: 13] = e;
        req_sig[r*64 +: 64] = sg;
    endtask

    // Drives one job on requester r; lat counts cycles from accept to resp_valid.
    task automatic run_job(input int r, input bit clr_at_done, output int lat,
                           output logic [63:0] data, output logic [N-1:0] rv, output bit timeout);
        logic [N-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        lat = 0;
        data = '0;
        rv = '0;
        timeout = 1'b0;
        req_valid[r] = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready != '0) break;
            tick();
        end
        if (req_ready !== oh) begin
            timeout = 1'b1;
            req_valid[r] = 1'b0;
            return;
        end
        tick();
        req_valid[r] = 1'b0;
        lat = 1;
        while (resp_valid == '0 && lat < 20) begin
            if (clr_at_done && core_flag_vld) flags_clr = 1'b1;
            tick();
            flags_clr = 1'b0;
            lat++;
        end
        if (resp_valid == '0) timeout = 1'b1;
        rv = resp_valid;
        data = resp_data;
    endtask

    task automatic test_reset();
        req_valid = '1;
        flags_clr = 1'b0;
        req_sign  = '0;
        req_exp   = '0;
        req_sig   = '0;
        #12;
        checks++;
        if (req_ready !== '0 || resp_valid !== '0) begin
            errors++;
            $display("FAIL reset_handshake got ready=%b resp_valid=%b want 0/0", req_ready, resp_valid);
        end
        checks++;
        if (resp_data !== 64'd0 || flags !== 32'd0 || core_flag_i !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got data=%h flags=%h flag_i=%h want 0", resp_data, flags, core_flag_i);
        end
        checks++;
        if (core_start !== 1'b0 || {core_sign, core_exp, core_sig} !== '0) begin
            errors++;
            $display("FAIL reset_core got start=%b sign=%b exp=%h sig=%h want 0", core_start, core_sign, core_exp, core_sig);
        end
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        int lat; logic [63:0] d; logic [N-1:0] rv; bit to;
        set_req(0, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000);
        run_job(0, 1'b0, lat, d, rv, to);
        checks++;
        if (to) begin errors++; $display("FAIL normal_timeout got no handshake want accept+resp"); end
        checks++;
        if (d !== 64'h3FF0_0000_0000_0000) begin errors++; $display("FAIL normal_data got %h want 3ff0000000000000", d); end
        checks++;
        if (lat != 5 || rv !== 4'b0001) begin errors++; $display("FAIL normal_timing got lat=%0d rv=%b want 5/0001", lat, rv); end
        checks++;
        if (flags !== 32'h0) begin errors++; $display("FAIL normal_flags got %h want 0", flags); end
        tick();
    endtask

    task automatic test_inexact();
        int lat; logic [63:0] d; logic [N-1:0] rv; bit to;
        set_req(0, 1'b0, 13'h3FE, 64'h4000_0000_0000_0001);
        run_job(0, 1'b0, lat, d, rv, to);
        checks++;
        if (to || d !== 64'h3FF0_0000_0000_0000) begin
            errors++;
            $display("FAIL inexact_data got %h (timeout=%0d) want 3ff0000000000000", d, to);
        end
        checks++;
        if (flags !== 32'h1) begin errors++; $display("FAIL inexact_flags got %h want 1", flags); end
        checks++;
        if (lat != 5) begin errors++; $display("FAIL inexact_lat got %0d want 5", lat); end
        tick();
    endtask

    task automatic test_flag_clear();
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        checks++;
        if (flags !== 32'h0) begin errors++; $display("FAIL flag_clear got %h want 0", flags); end
    endtask

    task automatic test_flag_race();
        int lat; logic [63:0] d; logic [N-1:0] rv; bit to;
        set_req(0, 1'b0, 13'h3FE, 64'h4000_0000_0000_0001);
        run_job(0, 1'b1, lat, d, rv, to);
        checks++;
        if (to) begin errors++; $display("FAIL race_timeout got no handshake want accept+resp"); end
        checks++;
        if (flags !== 32'h1) begin errors++; $display("FAIL race_flags got %h want 1", flags); end
        tick();
    endtask

    task automatic test_overflow();
        int lat; logic [63:0] d; logic [N-1:0] rv; bit to;
        set_req(2, 1'b1, 13'h7FF, 64'h4000_0000_0000_0000);
        run_job(2, 1'b0, lat, d, rv, to);
        checks++;
        if (to || d !== 64'hFFF0_0000_0000_0000) begin
            errors++;
            $display("FAIL overflow_data got %h (timeout=%0d) want fff0000000000000", d, to);
        end
        checks++;
        if (flags !== 32'h9) begin errors++; $display("FAIL overflow_flags got %h want 9", flags); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL overflow_lat got %0d want 4", lat); end
        checks++;
        if (rv !== 4'b0100) begin errors++; $display("FAIL overflow_resp_valid got %b want 0100", rv); end
        tick();
    endtask

    task automatic test_reset_mid_issue();
        int lat; logic [63:0] d; logic [N-1:0] rv; bit to; bit seen;
        set_req(1, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000);
        req_valid[1] = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_accept got %b want 0010", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        checks++;
        if (core_start !== 1'b1) begin errors++; $display("FAIL midrst_issue got start=%b want 1", core_start); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (core_start !== 1'b0 || resp_data !== 64'd0 || flags !== 32'd0) begin
            errors++;
            $display("FAIL midrst_async got start=%b data=%h flags=%h want 0/0/0", core_start, resp_data, flags);
        end
        checks++;
        if ({core_sign, core_exp, core_sig} !== '0 || req_ready !== '0 || resp_valid !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got exp=%h sig=%h ready=%b rv=%b want 0", core_exp, core_sig, req_ready, resp_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resp_valid !== '0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_no_resp got resp_valid after reset want none"); end
        set_req(3, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000);
        run_job(3, 1'b0, lat, d, rv, to);
        checks++;
        if (to || d !== 64'h3FF0_0000_0000_0000 || rv !== 4'b1000 || lat != 5) begin
            errors++;
            $display("FAIL midrst_next_job got data=%h rv=%b lat=%0d to=%0d want 3ff0000000000000/1000/5/0", d, rv, lat, to);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int ngrant, nresp, gi, ri;
        logic [63:0] want;
        ngrant = 0;
        nresp  = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 13'h3FE + 13'(i), 64'h4000_0000_0000_0000);
        req_valid = '1;
        #1;
        for (int c = 0; c < 80 && nresp < 5; c++) begin
            if (resp_valid != '0) begin
                ri = -1;
                for (int k = 0; k < N; k++) if (resp_valid == (4'b0001 << k)) ri = k;
                want = 64'h3FF0_0000_0000_0000 + (64'(order[nresp]) << 52);
                checks++;
                if (ri != order[nresp] || resp_data !== want) begin
                    errors++;
                    $display("FAIL rr_resp%0d got rv=%b data=%h want idx=%0d data=%h", nresp, resp_valid, resp_data, order[nresp], want);
                end
                nresp++;
            end
            if (req_ready != '0 && ngrant < 5) begin
                gi = -1;
                for (int k = 0; k < N; k++) if (req_ready == (4'b0001 << k)) gi = k;
                checks++;
                if (gi != order[ngrant]) begin
                    errors++;
                    $display("FAIL rr_grant%0d got ready=%b want idx=%0d", ngrant, req_ready, order[ngrant]);
                end
                ngrant++;
            end
            tick();
            if (ngrant == 5) req_valid = '0;
        end
        req_valid = '0;
        checks++;
        if (ngrant != 5 || nresp != 5) begin
            errors++;
            $display("FAIL rr_counts got grants=%0d resps=%0d want 5/5", ngrant, nresp);
        end
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (resp_valid !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL rr_quiet got rv=%b ready=%b want 0/0", resp_valid, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_inexact();
        test_flag_clear();
        test_flag_race();
        test_overflow();
        test_reset_mid_issue();
        test_round_robin();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
